// File: rtl/ysyx_210544_mem_stage_if.sv
// ysyx_210544_mem_stage_if
//   Data memory bus between the memory-access stage (master) and the data
//   memory agent (slave). One request is outstanding at a time. The master
//   holds every request field stable until rw_ack is sampled high on a clock
//   edge.
//   rw_req   : master -> slave, bus request
//   rw_ack   : slave -> master, access done (read data valid for loads)
//   rw_addr  : 8-byte aligned address
//   rw_wen   : 1 = store, 0 = load
//   rw_wdata : store data already shifted into its byte lanes
//   rw_wmask : byte strobes for stores
//   rw_size  : 0 = byte, 1 = half, 2 = word, 3 = dword
//   rw_rdata : full read dword returned by the slave
interface ysyx_210544_mem_stage_if;
  logic        rw_req;
  logic        rw_ack;
  logic [63:0] rw_addr;
  logic        rw_wen;
  logic [63:0] rw_wdata;
  logic [7:0]  rw_wmask;
  logic [1:0]  rw_size;
  logic [63:0] rw_rdata;

  modport master (
    output rw_req, rw_addr, rw_wen, rw_wdata, rw_wmask, rw_size,
    input  rw_ack, rw_rdata
  );

  modport slave (
    input  rw_req, rw_addr, rw_wen, rw_wdata, rw_wmask, rw_size,
    output rw_ack, rw_rdata
  );
endinterface

// File: rtl/ysyx_210544_mem_stage.sv
// ysyx_210544_mem_stage
//   Memory-access stage between execute and write-back. Takes one executed
//   instruction per executed req/ack handshake, performs at most one aligned
//   load or store on the data bus, extends load data and hands the result to
//   write-back through the memoryed req/ack handshake.
//   Optional feature macro: MEM_MMIO_SKIPCMT_EN -- when defined, any load or
//   store whose address is below MMIO_LIMIT forces o_mem_skipcmt.
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   i_mem_executed_req / o_mem_executed_ack : handshake from execute
//   i_mem_*              : instruction fields latched on that handshake
//   memBus               : data memory bus (master side)
//   o_mem_memoryed_req / i_mem_memoryed_ack : handshake to write-back
//   o_mem_*              : results to write-back, zero outside DONE
//   o_mem_misalign       : access would have crossed an 8-byte boundary
// Opcode codes mirror the INST_* load/store values of defines.v.
module ysyx_210544_mem_stage #(
  parameter logic [63:0] MMIO_LIMIT = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_executed_req,
  output logic        o_mem_executed_ack,
  input  logic [7:0]  i_mem_inst_opcode,
  input  logic [63:0] i_mem_pc,
  input  logic [31:0] i_mem_inst,
  input  logic [63:0] i_mem_op1,
  input  logic [63:0] i_mem_op2,
  input  logic [63:0] i_mem_op3,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_rd_wen,
  input  logic [63:0] i_mem_rd_wdata,
  input  logic        i_mem_nocmt,
  input  logic        i_mem_skipcmt,
  input  logic [31:0] i_mem_intrNo,
  ysyx_210544_mem_stage_if.master memBus,
  output logic        o_mem_memoryed_req,
  input  logic        i_mem_memoryed_ack,
  output logic [63:0] o_mem_pc,
  output logic [31:0] o_mem_inst,
  output logic [4:0]  o_mem_rd,
  output logic        o_mem_rd_wen,
  output logic [63:0] o_mem_rd_wdata,
  output logic        o_mem_nocmt,
  output logic        o_mem_skipcmt,
  output logic [31:0] o_mem_intrNo,
  output logic        o_mem_misalign
);
  localparam logic [7:0] INST_LB  = 8'h01, INST_LH  = 8'h02, INST_LW  = 8'h03;
  localparam logic [7:0] INST_LD  = 8'h04, INST_LBU = 8'h05, INST_LHU = 8'h06;
  localparam logic [7:0] INST_LWU = 8'h07, INST_SB  = 8'h08, INST_SH  = 8'h09;
  localparam logic [7:0] INST_SW  = 8'h0A, INST_SD  = 8'h0B;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d, rdWdata_q, rdWdata_d, wdata_q, wdata_d;
  logic [31:0] inst_q, inst_d, intrNo_q, intrNo_d;
  logic [4:0]  rd_q, rd_d;
  logic        rdWen_q, rdWen_d, nocmt_q, nocmt_d, skipcmt_q, skipcmt_d;
  logic        misalign_q, misalign_d, isStore_q, isStore_d;
  logic        isLoad_q, isLoad_d, isUnsigned_q, isUnsigned_d;
  logic [60:0] addrHi_q, addrHi_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  wmask_q, wmask_d;

  logic [63:0] addrIn, shiftedRdata, loadValue;
  logic [2:0]  offIn;
  logic [1:0]  sizeIn;
  logic        loadIn, storeIn, unsignedIn, memOpIn, misalignIn, mmioIn;
  logic [7:0]  baseMask;

  // Decode the opcode into access kind, size and extension type.
  always_comb begin
    loadIn     = 1'b0;
    storeIn    = 1'b0;
    unsignedIn = 1'b0;
    sizeIn     = 2'd0;
    case (i_mem_inst_opcode)
      INST_LB:  begin loadIn = 1'b1; sizeIn = 2'd0; end
      INST_LH:  begin loadIn = 1'b1; sizeIn = 2'd1; end
      INST_LW:  begin loadIn = 1'b1; sizeIn = 2'd2; end
      INST_LD:  begin loadIn = 1'b1; sizeIn = 2'd3; end
      INST_LBU: begin loadIn = 1'b1; unsignedIn = 1'b1; sizeIn = 2'd0; end
      INST_LHU: begin loadIn = 1'b1; unsignedIn = 1'b1; sizeIn = 2'd1; end
      INST_LWU: begin loadIn = 1'b1; unsignedIn = 1'b1; sizeIn = 2'd2; end
      INST_SB:  begin storeIn = 1'b1; sizeIn = 2'd0; end
      INST_SH:  begin storeIn = 1'b1; sizeIn = 2'd1; end
      INST_SW:  begin storeIn = 1'b1; sizeIn = 2'd2; end
      INST_SD:  begin storeIn = 1'b1; sizeIn = 2'd3; end
      default:  ;
    endcase
  end

  // A pending interrupt turns a load/store into a plain pass-through.
  assign addrIn     = i_mem_op1 + i_mem_op2;
  assign offIn      = addrIn[2:0];
  assign memOpIn    = (loadIn | storeIn) & (i_mem_intrNo == 32'd0);
  assign misalignIn = memOpIn & (({1'b0, offIn} + (4'd1 << sizeIn)) > 4'd8);

  always_comb begin
    case (sizeIn)
      2'd0:    baseMask = 8'h01;
      2'd1:    baseMask = 8'h03;
      2'd2:    baseMask = 8'h0F;
      default: baseMask = 8'hFF;
    endcase
  end

`ifdef MEM_MMIO_SKIPCMT_EN
  assign mmioIn = memOpIn & (addrIn < MMIO_LIMIT);
`else
  logic unusedMmioLimit;
  assign unusedMmioLimit = ^MMIO_LIMIT;
  assign mmioIn = 1'b0;
`endif

  // Bring the addressed bytes of the read dword down to bit 0 and extend.
  assign shiftedRdata = memBus.rw_rdata >> {off_q, 3'b000};
  always_comb begin
    case (size_q)
      2'd0:    loadValue = isUnsigned_q ? {56'd0, shiftedRdata[7:0]}
                                        : {{56{shiftedRdata[7]}}, shiftedRdata[7:0]};
      2'd1:    loadValue = isUnsigned_q ? {48'd0, shiftedRdata[15:0]}
                                        : {{48{shiftedRdata[15]}}, shiftedRdata[15:0]};
      2'd2:    loadValue = isUnsigned_q ? {32'd0, shiftedRdata[31:0]}
                                        : {{32{shiftedRdata[31]}}, shiftedRdata[31:0]};
      default: loadValue = shiftedRdata;
    endcase
  end

  // Next-state and latch logic: capture the instruction in IDLE, collect the
  // load data when the bus acknowledges, release on the write-back handshake.
  always_comb begin
    state_d = state_q;       pc_d = pc_q;             inst_d = inst_q;
    rd_d = rd_q;             rdWen_d = rdWen_q;       rdWdata_d = rdWdata_q;
    nocmt_d = nocmt_q;       skipcmt_d = skipcmt_q;   intrNo_d = intrNo_q;
    misalign_d = misalign_q; isStore_d = isStore_q;   isLoad_d = isLoad_q;
    isUnsigned_d = isUnsigned_q; addrHi_d = addrHi_q; off_d = off_q;
    size_d = size_q;         wdata_d = wdata_q;       wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (i_mem_executed_req) begin
          pc_d         = i_mem_pc;
          inst_d       = i_mem_inst;
          rd_d         = i_mem_rd;
          rdWen_d      = i_mem_rd_wen & ~misalignIn & (i_mem_intrNo == 32'd0);
          rdWdata_d    = i_mem_rd_wdata;
          nocmt_d      = i_mem_nocmt;
          skipcmt_d    = i_mem_skipcmt | mmioIn;
          intrNo_d     = i_mem_intrNo;
          misalign_d   = misalignIn;
          isStore_d    = storeIn & memOpIn;
          isLoad_d     = loadIn & memOpIn;
          isUnsigned_d = unsignedIn;
          addrHi_d     = addrIn[63:3];
          off_d        = offIn;
          size_d       = sizeIn;
          wdata_d      = i_mem_op3 << {offIn, 3'b000};
          wmask_d      = storeIn ? (baseMask << offIn) : 8'h00;
          state_d      = (memOpIn & ~misalignIn) ? BUS : DONE;
        end
      end
      BUS: begin
        if (memBus.rw_ack) begin
          if (isLoad_q) rdWdata_d = loadValue;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_mem_memoryed_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wipes every latched field so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;   pc_q <= '0;        inst_q <= '0;      rd_q <= '0;
      rdWen_q <= 1'b0;   rdWdata_q <= '0;   nocmt_q <= 1'b0;   skipcmt_q <= 1'b0;
      intrNo_q <= '0;    misalign_q <= 1'b0; isStore_q <= 1'b0; isLoad_q <= 1'b0;
      isUnsigned_q <= 1'b0; addrHi_q <= '0; off_q <= '0;       size_q <= '0;
      wdata_q <= '0;     wmask_q <= '0;
    end else begin
      state_q <= state_d; pc_q <= pc_d;     inst_q <= inst_d;  rd_q <= rd_d;
      rdWen_q <= rdWen_d; rdWdata_q <= rdWdata_d; nocmt_q <= nocmt_d;
      skipcmt_q <= skipcmt_d; intrNo_q <= intrNo_d; misalign_q <= misalign_d;
      isStore_q <= isStore_d; isLoad_q <= isLoad_d; isUnsigned_q <= isUnsigned_d;
      addrHi_q <= addrHi_d; off_q <= off_d; size_q <= size_d;
      wdata_q <= wdata_d; wmask_q <= wmask_d;
    end
  end

  // Outputs are qualified by state so nothing stale leaks outside its phase.
  assign o_mem_executed_ack = (state_q == IDLE) & ~rst;
  assign memBus.rw_req      = (state_q == BUS);
  assign memBus.rw_addr     = (state_q == BUS) ? {addrHi_q, 3'b000} : 64'd0;
  assign memBus.rw_wen      = (state_q == BUS) & isStore_q;
  assign memBus.rw_wdata    = (state_q == BUS) ? wdata_q : 64'd0;
  assign memBus.rw_wmask    = (state_q == BUS) ? wmask_q : 8'd0;
  assign memBus.rw_size     = (state_q == BUS) ? size_q : 2'd0;
  assign o_mem_memoryed_req = (state_q == DONE);
  assign o_mem_pc           = (state_q == DONE) ? pc_q : 64'd0;
  assign o_mem_inst         = (state_q == DONE) ? inst_q : 32'd0;
  assign o_mem_rd           = (state_q == DONE) ? rd_q : 5'd0;
  assign o_mem_rd_wen       = (state_q == DONE) & rdWen_q;
  assign o_mem_rd_wdata     = (state_q == DONE) ? rdWdata_q : 64'd0;
  assign o_mem_nocmt        = (state_q == DONE) & nocmt_q;
  assign o_mem_skipcmt      = (state_q == DONE) & skipcmt_q;
  assign o_mem_intrNo       = (state_q == DONE) ? intrNo_q : 32'd0;
  assign o_mem_misalign     = (state_q == DONE) & misalign_q;
endmodule

// File: tb/tb_ysyx_210544_mem_stage.sv
// Testbench for ysyx_210544_mem_stage: directed load/store/pass-through
// sequence with a result scoreboard and a bus slave driven from the
// stimulus thread.
module tb_ysyx_210544_mem_stage;
  localparam logic [7:0] OP_LB = 8'h01, OP_LW = 8'h03, OP_LD = 8'h04;
  localparam logic [7:0] OP_LBU = 8'h05, OP_SH = 8'h09, OP_ADD = 8'h20;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rdWen;
    logic [63:0] rdWdata;
    logic        nocmt;
    logic        skipcmt;
    logic [31:0] intrNo;
    logic        misalign;
  } result_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        executedReq = 1'b0, memoryedAck = 1'b0;
  logic        executedAck, memoryedReq;
  logic [7:0]  opcode = '0;
  logic [63:0] pcIn = '0, op1 = '0, op2 = '0, op3 = '0, rdWdataIn = '0;
  logic [31:0] instIn = '0, intrNoIn = '0;
  logic [4:0]  rdIn = '0;
  logic        rdWenIn = 1'b0, nocmtIn = 1'b0, skipcmtIn = 1'b0;
  logic [63:0] pcOut, rdWdataOut;
  logic [31:0] instOut, intrNoOut;
  logic [4:0]  rdOut;
  logic        rdWenOut, nocmtOut, skipcmtOut, misalignOut;

  int checks = 0;
  int failures = 0;
  result_t expQ[$];
  logic [63:0] nextPc = 64'h8000_0000;

  ysyx_210544_mem_stage_if memBus ();

  ysyx_210544_mem_stage dut (
    .clk(clk), .rst(rst),
    .i_mem_executed_req(executedReq), .o_mem_executed_ack(executedAck),
    .i_mem_inst_opcode(opcode), .i_mem_pc(pcIn), .i_mem_inst(instIn),
    .i_mem_op1(op1), .i_mem_op2(op2), .i_mem_op3(op3),
    .i_mem_rd(rdIn), .i_mem_rd_wen(rdWenIn), .i_mem_rd_wdata(rdWdataIn),
    .i_mem_nocmt(nocmtIn), .i_mem_skipcmt(skipcmtIn), .i_mem_intrNo(intrNoIn),
    .memBus(memBus),
    .o_mem_memoryed_req(memoryedReq), .i_mem_memoryed_ack(memoryedAck),
    .o_mem_pc(pcOut), .o_mem_inst(instOut), .o_mem_rd(rdOut),
    .o_mem_rd_wen(rdWenOut), .o_mem_rd_wdata(rdWdataOut),
    .o_mem_nocmt(nocmtOut), .o_mem_skipcmt(skipcmtOut),
    .o_mem_intrNo(intrNoOut), .o_mem_misalign(misalignOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction across the executed handshake and queue its result.
  task automatic applyStimulus(input logic [7:0] opc, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] sdata, input logic wen, input logic [63:0] wdata,
                               input logic [31:0] intr, input logic expBus,
                               input logic expRdWen, input logic [63:0] expRdWdata,
                               input logic expMisalign, input logic nocmt, input logic skip);
    result_t r;
    @(negedge clk);
    opcode = opc; op1 = a; op2 = b; op3 = sdata; rdWenIn = wen; rdWdataIn = wdata;
    intrNoIn = intr; pcIn = nextPc; instIn = nextPc[31:0] ^ 32'h0000_0013;
    rdIn = nextPc[6:2]; nocmtIn = nocmt; skipcmtIn = skip;
    r.pc = nextPc; r.inst = instIn; r.rd = rdIn; r.rdWen = expRdWen;
    r.rdWdata = expRdWdata; r.nocmt = nocmt; r.skipcmt = skip;
    r.intrNo = intr; r.misalign = expMisalign;
    expQ.push_back(r);
    nextPc = nextPc + 64'd4;
    executedReq = 1'b1;
    #1 checkOutput("executed_ack_idle", {63'd0, executedAck}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    executedReq = 1'b0;
    checkOutput("rw_req_after_hs", {63'd0, memBus.rw_req}, {63'd0, expBus});
  endtask

  // Act as the memory agent: check the request, stall, then acknowledge.
  task automatic busRespond(input logic [63:0] expAddr, input logic expWen, input logic [7:0] expMask,
                            input logic [63:0] expWdata, input logic [1:0] expSize,
                            input logic [63:0] rdata, input int hold);
    checkOutput("rw_addr", memBus.rw_addr, expAddr);
    checkOutput("rw_wen", {63'd0, memBus.rw_wen}, {63'd0, expWen});
    checkOutput("rw_wmask", {56'd0, memBus.rw_wmask}, {56'd0, expMask});
    checkOutput("rw_wdata", memBus.rw_wdata, expWdata);
    checkOutput("rw_size", {62'd0, memBus.rw_size}, {62'd0, expSize});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("rw_req_held", {63'd0, memBus.rw_req}, 64'd1);
      checkOutput("rw_addr_held", memBus.rw_addr, expAddr);
    end
    memBus.rw_rdata = rdata;
    memBus.rw_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    memBus.rw_ack = 1'b0;
    memBus.rw_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    checkOutput("rw_req_drop", {63'd0, memBus.rw_req}, 64'd0);
  endtask

  // Wait for the result, compare against the scoreboard, stall, then accept.
  task automatic waitResult(input int hold);
    logic seen = 1'b0;
    result_t e;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (memoryedReq === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checkOutput("memoryed_req_timeout", {63'd0, seen}, 64'd1);
    if (seen && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("pc", pcOut, e.pc);
      checkOutput("inst", {32'd0, instOut}, {32'd0, e.inst});
      checkOutput("rd", {59'd0, rdOut}, {59'd0, e.rd});
      checkOutput("rd_wen", {63'd0, rdWenOut}, {63'd0, e.rdWen});
      checkOutput("rd_wdata", rdWdataOut, e.rdWdata);
      checkOutput("nocmt", {63'd0, nocmtOut}, {63'd0, e.nocmt});
      checkOutput("skipcmt", {63'd0, skipcmtOut}, {63'd0, e.skipcmt});
      checkOutput("intrNo", {32'd0, intrNoOut}, {32'd0, e.intrNo});
      checkOutput("misalign", {63'd0, misalignOut}, {63'd0, e.misalign});
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checkOutput("memoryed_req_held", {63'd0, memoryedReq}, 64'd1);
        checkOutput("rd_wdata_held", rdWdataOut, e.rdWdata);
        checkOutput("executed_ack_busy", {63'd0, executedAck}, 64'd0);
      end
      memoryedAck = 1'b1;
      @(posedge clk);
      @(negedge clk);
      memoryedAck = 1'b0;
      checkOutput("memoryed_req_drop", {63'd0, memoryedReq}, 64'd0);
      checkOutput("executed_ack_back", {63'd0, executedAck}, 64'd1);
      checkOutput("misalign_idle", {63'd0, misalignOut}, 64'd0);
    end
  endtask

  initial begin
    memBus.rw_ack = 1'b0;
    memBus.rw_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_executed_ack", {63'd0, executedAck}, 64'd0);
    checkOutput("reset_memoryed_req", {63'd0, memoryedReq}, 64'd0);
    checkOutput("reset_rw_req", {63'd0, memBus.rw_req}, 64'd0);
    checkOutput("reset_rd_wdata", rdWdataOut, 64'd0);
    rst = 1'b0;
    #1 checkOutput("first_executed_ack", {63'd0, executedAck}, 64'd1);

    $display("[TB] LD aligned dword");
    applyStimulus(OP_LD, 64'h8000_0010, 64'd8, 64'd0, 1'b1, 64'h55, 32'd0, 1'b1,
                  1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b0);
    busRespond(64'h8000_0018, 1'b0, 8'h00, 64'd0, 2'd3, 64'h1122_3344_5566_7788, 2);
    waitResult(0);

    $display("[TB] LB / LBU sign and zero extension");
    applyStimulus(OP_LB, 64'h8000_0000, 64'd3, 64'd0, 1'b1, 64'd0, 32'd0, 1'b1,
                  1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 1'b0);
    busRespond(64'h8000_0000, 1'b0, 8'h00, 64'd0, 2'd0, 64'h0000_0000_8000_0000, 0);
    waitResult(0);
    applyStimulus(OP_LBU, 64'h8000_0000, 64'd3, 64'd0, 1'b1, 64'd0, 32'd0, 1'b1,
                  1'b1, 64'h0000_0000_0000_0080, 1'b0, 1'b1, 1'b0);
    busRespond(64'h8000_0000, 1'b0, 8'h00, 64'd0, 2'd0, 64'h0000_0000_8000_0000, 1);
    waitResult(0);

    $display("[TB] SH into upper lanes");
    applyStimulus(OP_SH, 64'h8000_0004, 64'd2, 64'h0000_0000_0000_BEEF, 1'b0, 64'h77, 32'd0, 1'b1,
                  1'b0, 64'h77, 1'b0, 1'b0, 1'b1);
    busRespond(64'h8000_0000, 1'b1, 8'hC0, 64'hBEEF_0000_0000_0000, 2'd1, 64'd0, 0);
    waitResult(0);

    $display("[TB] ADD pass-through with backpressure");
    applyStimulus(OP_ADD, 64'h1, 64'h4, 64'd0, 1'b1, 64'd5, 32'd0, 1'b0,
                  1'b1, 64'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("add_latency", {63'd0, memoryedReq}, 64'd1);
    waitResult(4);

    $display("[TB] LW crossing a dword boundary");
    applyStimulus(OP_LW, 64'h8000_0000, 64'd6, 64'd0, 1'b1, 64'h99, 32'd0, 1'b0,
                  1'b0, 64'h99, 1'b1, 1'b0, 1'b0);
    waitResult(1);

    $display("[TB] LD suppressed by interrupt");
    applyStimulus(OP_LD, 64'h8000_1000, 64'd0, 64'd0, 1'b1, 64'h1234, 32'd7, 1'b0,
                  1'b0, 64'h1234, 1'b0, 1'b0, 1'b0);
    waitResult(0);

    $display("[TB] reset while waiting on the bus");
    applyStimulus(OP_LD, 64'h8000_0020, 64'd0, 64'd0, 1'b1, 64'd0, 32'd0, 1'b1,
                  1'b1, 64'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bus_rw_req", {63'd0, memBus.rw_req}, 64'd0);
    checkOutput("rst_bus_rw_addr", memBus.rw_addr, 64'd0);
    checkOutput("rst_bus_memoryed_req", {63'd0, memoryedReq}, 64'd0);
    checkOutput("rst_bus_executed_ack", {63'd0, executedAck}, 64'd0);
    if (expQ.size() > 0) void'(expQ.pop_back());
    rst = 1'b0;
    applyStimulus(OP_LD, 64'h8000_0028, 64'd0, 64'd0, 1'b1, 64'd0, 32'd0, 1'b1,
                  1'b1, 64'hCAFE_F00D_0BAD_BEEF, 1'b0, 1'b0, 1'b0);
    busRespond(64'h8000_0028, 1'b0, 8'h00, 64'd0, 2'd3, 64'hCAFE_F00D_0BAD_BEEF, 0);
    waitResult(0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
